// File: rtl/data_bus_ctrl.sv
// Memory-mapped bus controller: decodes a core request against per-region base/limit windows,
// forwards it to one slave, waits for its ack with a timeout and returns ready/err/rdata.
module data_bus_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_REGIONS  = 2,
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = {32'd128, 32'd0},
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT = {32'd130, 32'd127},
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req,
  input  logic                            i_we,
  input  logic [ADDR_WIDTH-1:0]           i_addr,
  input  logic [DATA_WIDTH-1:0]           i_wdata,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic                            o_ready,
  output logic                            o_err,
  output logic [N_REGIONS-1:0]            o_sel,
  output logic [N_REGIONS-1:0]            o_we,
  output logic [ADDR_WIDTH-1:0]           o_addr,
  output logic [DATA_WIDTH-1:0]           o_wdata,
  input  logic [N_REGIONS*DATA_WIDTH-1:0] i_rdata,
  input  logic [N_REGIONS-1:0]            i_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESP_OK  = 2'd2,
    RESP_ERR = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_lat_q, we_lat_d;
  logic [N_REGIONS-1:0]    sel_q, sel_d;
  logic [N_REGIONS-1:0]    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic [N_REGIONS-1:0]    dec_sel_s;
  logic [ADDR_WIDTH-1:0]   dec_off_s;
  logic                    ack_s;
  logic [DATA_WIDTH-1:0]   slave_rdata_s;

  // Range check by widened subtraction: a borrow out of either side means the address is outside.
  function automatic logic region_hit(input logic [ADDR_WIDTH-1:0] addr, input int idx);
    logic [ADDR_WIDTH:0] diff_lo;
    logic [ADDR_WIDTH:0] diff_hi;
    diff_lo = {1'b0, addr} - {1'b0, REGION_BASE[idx*ADDR_WIDTH +: ADDR_WIDTH]};
    diff_hi = {1'b0, REGION_LIMIT[idx*ADDR_WIDTH +: ADDR_WIDTH]} - {1'b0, addr};
    return !diff_lo[ADDR_WIDTH] && !diff_hi[ADDR_WIDTH];
  endfunction

  // Scanning from the top down lets the lowest hitting region overwrite any higher one.
  function automatic logic [N_REGIONS-1:0] decode_sel(input logic [ADDR_WIDTH-1:0] addr);
    logic [N_REGIONS-1:0] sel;
    sel = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (region_hit(addr, i)) begin
        sel    = '0;
        sel[i] = 1'b1;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] region_offset(input logic [ADDR_WIDTH-1:0] addr,
                                                           input logic [N_REGIONS-1:0] sel);
    logic [ADDR_WIDTH-1:0] off;
    off = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      off = off | ({ADDR_WIDTH{sel[i]}} & (addr - REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end
    return off;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] slave_mux(input logic [N_REGIONS*DATA_WIDTH-1:0] bus,
                                                       input logic [N_REGIONS-1:0] sel);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      d = d | ({DATA_WIDTH{sel[i]}} & bus[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    return d;
  endfunction

  // Address decode and selected-slave response steering.
  always_comb begin
    dec_sel_s     = decode_sel(i_addr);
    dec_off_s     = region_offset(i_addr, dec_sel_s);
    ack_s         = |(i_ack & sel_q);
    slave_rdata_s = slave_mux(i_rdata, sel_q);
  end

  // Next-state and registered-output logic; outputs are set on the edge entering each state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_lat_d = we_lat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_req) begin
          we_lat_d = i_we;
          if (|dec_sel_s) begin
            state_d = ACCESS;
            sel_d   = dec_sel_s;
            we_d    = i_we ? dec_sel_s : '0;
            addr_d  = dec_off_s;
            wdata_d = i_wdata;
          end else begin
            state_d = RESP_ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_s) begin
          state_d = RESP_OK;
          sel_d   = '0;
          we_d    = '0;
          ready_d = 1'b1;
          rdata_d = we_lat_q ? rdata_q : slave_rdata_s;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP_ERR;
          sel_d   = '0;
          we_d    = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP_OK:  state_d = IDLE;
      RESP_ERR: state_d = IDLE;
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        we_d    = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_lat_q <= 1'b0;
      sel_q    <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_lat_q <= we_lat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign o_sel   = sel_q;
  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_rdata = rdata_q;
  assign o_ready = ready_q;
  assign o_err   = err_q;

endmodule
